spi_byte_link: RTL and testbench

- Upstream byte-transport stage for the cartridge command decoder.
- Acts as a mode-0 SPI slave for the MCU link, oversampled in the system clock domain.
- Deserialises MOSI into bytes and buffers them in a small show-ahead FIFO presented on the rd_data/rd_valid/rd_ready interface.
- Serialises wr_data onto MISO and issues a one-cycle start pulse at each chip-select assertion.

---
 rtl/spi_link_pkg.sv | 10 +
 rtl/spi_byte_link_if.sv | 39 +++
 rtl/byte_fifo.sv | 67 ++++++
 rtl/spi_byte_link.sv | 162 ++++++++++++++++
 tb/tb_spi_byte_link.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_link_pkg.sv
// Shared constants and types for the SPI byte link.
package spi_link_pkg;

    localparam int unsigned SPI_BITS = 8;

    typedef logic [SPI_BITS-1:0] spi_byte_t;

    localparam spi_byte_t FILL_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spi_byte_link_if.sv
// Byte-level handshake bundle between the SPI link and the command decoder.
interface spi_byte_link_if;
    import spi_link_pkg::*;

    spi_byte_t rd_data;
    logic      rd_valid;
    logic      rd_ready;
    spi_byte_t wr_data;
    logic      wr_ready;
    logic      wr_valid;
    logic      start;
    logic      rx_overflow;
    logic      tx_underrun;

    modport slave (
        output rd_data,
        output rd_valid,
        input  rd_ready,
        input  wr_data,
        input  wr_ready,
        output wr_valid,
        output start,
        output rx_overflow,
        output tx_underrun
    );

    modport master (
        input  rd_data,
        input  rd_valid,
        output rd_ready,
        output wr_data,
        output wr_ready,
        input  wr_valid,
        input  start,
        input  rx_overflow,
        input  tx_underrun
    );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO with flush; head entry is presented combinationally.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push_i && !flush_i && ((count_q != CNT_FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + (PTR_W + 1)'(1);
            else if (do_pop && !do_push) count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CNT_FULL);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/spi_byte_link.sv
// Mode-0 SPI slave oversampled in the clk domain: MOSI bytes into a show-ahead FIFO,
// transmit bytes out on MISO, one start pulse per chip-select assertion.
module spi_byte_link
    import spi_link_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter spi_byte_t   FILL_BYTE  = FILL_BYTE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            spi_sck,
    input  logic            spi_cs_n,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic            spi_miso_oe,
    spi_byte_link_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SPI_BITS);

    logic sck_s1_q, sck_s2_q, sck_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q;
    logic [2:0] vld_q;

    logic             active_q, active_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    spi_byte_t        rx_sh_q, rx_sh_d;
    spi_byte_t        tx_sh_q, tx_sh_d;
    logic             ovf_q, ovf_d;
    logic             und_q, und_d;
    logic             oe_q, oe_d;

    logic      cs_fall, sck_rise, sck_fall, selected;
    logic      rx_bit, tx_bit, byte_done, tx_load, wr_valid;
    spi_byte_t push_byte, fifo_head;
    logic      fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // vld_q tracks when each sync stage holds a pin-derived value rather than its reset value,
    // so a select already low at reset release never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_h_q   <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            vld_q     <= '0;
        end else begin
            sck_s1_q  <= spi_sck;
            sck_s2_q  <= sck_s1_q;
            sck_h_q   <= sck_s2_q;
            cs_s1_q   <= spi_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            vld_q     <= {vld_q[1:0], 1'b1};
        end
    end

    always_comb begin
        cs_fall   = vld_q[2] && cs_h_q && !cs_s2_q;
        sck_rise  = sck_s2_q && !sck_h_q;
        sck_fall  = !sck_s2_q && sck_h_q;
        selected  = active_q && !cs_s2_q;
        rx_bit    = selected && sck_rise && !cs_fall;
        tx_bit    = selected && sck_fall && !cs_fall;
        byte_done = rx_bit && (bit_cnt_q == CNT_W'(SPI_BITS - 1));
        tx_load   = cs_fall || byte_done;
        push_byte = {rx_sh_q[SPI_BITS-2:0], mosi_s2_q};
        fifo_pop  = bus.rd_ready && (fifo_count != '0);
    end

    always_comb begin
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        ovf_d     = ovf_q;
        und_d     = und_q;
        oe_d      = !cs_s2_q;
        wr_valid  = 1'b0;

        if (cs_s2_q) active_d = 1'b0;
        if (cs_fall) active_d = 1'b1;

        if (rx_bit) begin
            rx_sh_d   = push_byte;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        // The falling edge right after a byte boundary must keep the freshly loaded MSB.
        if (tx_bit && (bit_cnt_q != '0)) tx_sh_d = {tx_sh_q[SPI_BITS-2:0], 1'b0};

        if (cs_fall) begin
            bit_cnt_d = '0;
            ovf_d     = 1'b0;
            und_d     = 1'b0;
        end
        if (byte_done && fifo_full && !fifo_pop) ovf_d = 1'b1;

        if (tx_load) begin
            if (bus.wr_ready) begin
                tx_sh_d  = bus.wr_data;
                wr_valid = 1'b1;
            end else begin
                tx_sh_d = FILL_BYTE;
                und_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            bit_cnt_q <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= FILL_BYTE;
            ovf_q     <= 1'b0;
            und_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sh_q   <= rx_sh_d;
            tx_sh_q   <= tx_sh_d;
            ovf_q     <= ovf_d;
            und_q     <= und_d;
            oe_q      <= oe_d;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SPI_BITS)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (cs_fall),
        .push_i      (byte_done),
        .push_data_i (push_byte),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign spi_miso        = tx_sh_q[SPI_BITS-1];
    assign spi_miso_oe     = oe_q;
    assign bus.rd_data     = fifo_head;
    assign bus.rd_valid    = !fifo_empty;
    assign bus.wr_valid    = wr_valid;
    assign bus.start       = cs_fall;
    assign bus.rx_overflow = ovf_q;
    assign bus.tx_underrun = und_q;

endmodule

// File: tb/tb_spi_byte_link.sv
// Scoreboard bench for spi_byte_link: an SPI master task drives bytes, a monitor pops
// the RX FIFO and compares against queued expectations.
module tb_spi_byte_link;
    import spi_link_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe;

    spi_byte_link_if bus ();

    spi_byte_link #(
        .FIFO_DEPTH (4),
        .FILL_BYTE  (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    bit pop_en = 1'b1;
    bit lat_en = 1'b1;
    longint last_rise = 0;
    int start_cnt = 0;
    int wv_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RX scoreboard monitor; also drives the one-cycle pop strobe.
    initial begin
        bus.rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rd_ready) begin
                bus.rd_ready = 1'b0;
            end else if (bus.rd_valid && pop_en && !reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none at %0t",
                             bus.rd_data, $time);
                end else begin
                    check("rx_byte", bus.rd_data, exp_q.pop_front());
                    if (lat_en) check("rx_latency", (($time - last_rise) <= 45), 1);
                end
                bus.rd_ready = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.start) start_cnt++;
    end

    // Transmit producer: presents the head of tx_q, retires it after each wr_valid.
    initial begin
        forever begin
            bus.wr_ready = (tx_q.size() != 0);
            bus.wr_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
            @(negedge clk);
            if (bus.wr_valid) begin
                wv_cnt++;
                @(posedge clk);
                #1;
                if (tx_q.size() != 0) void'(tx_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic cs_assert();
        spi_cs_n = 1'b0;
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic cs_release();
        #40;
        spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] got);
        got = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = d[i];
            #40;
            spi_sck = 1'b1;
            got = {got[6:0], spi_miso};
            if (i == 0) last_rise = $time;
            #40;
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] d, input logic [7:0] miso_exp, input bit expect_rx);
        logic [7:0] got;
        if (expect_rx) exp_q.push_back(d);
        spi_bits(d, 8, got);
        check("miso_byte", got, miso_exp);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.rd_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rx_pending", exp_q.size(), 0);
    endtask

    initial begin
        int s0, w0;
        logic [7:0] junk;
        bus.wr_ready = 1'b0;
        bus.wr_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_start", bus.start, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_miso", spi_miso, 1);
        check("rst_overflow", bus.rx_overflow, 0);
        check("rst_underrun", bus.tx_underrun, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Four bytes, consumer popping as they arrive.
        s0 = start_cnt;
        cs_assert();
        check("miso_oe_sel", spi_miso_oe, 1);
        spi_byte(8'h01, 8'hFF, 1'b1);
        spi_byte(8'h12, 8'hFF, 1'b1);
        spi_byte(8'h34, 8'hFF, 1'b1);
        spi_byte(8'h56, 8'hFF, 1'b1);
        cs_release();
        check("miso_oe_desel", spi_miso_oe, 0);
        drain();
        check("start_once", start_cnt - s0, 1);

        // Transmit path with three queued bytes over a three-byte transfer.
        s0 = start_cnt;
        w0 = wv_cnt;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'h77);
        @(negedge clk);
        cs_assert();
        spi_byte(8'hC1, 8'hA5, 1'b1);
        check("underrun_cleared", bus.tx_underrun, 0);
        spi_byte(8'hC2, 8'h3C, 1'b1);
        spi_byte(8'hC3, 8'h77, 1'b1);
        cs_release();
        drain();
        check("wr_valid_count", wv_cnt - w0, 3);
        check("underrun_after_queue", bus.tx_underrun, 1);
        check("start_tx", start_cnt - s0, 1);

        // No transmit data at all.
        w0 = wv_cnt;
        cs_assert();
        spi_byte(8'h5A, 8'hFF, 1'b1);
        spi_byte(8'hA5, 8'hFF, 1'b1);
        cs_release();
        drain();
        check("underrun_set", bus.tx_underrun, 1);
        check("wr_valid_none", wv_cnt - w0, 0);

        // Overflow: six bytes into a depth-4 FIFO with the consumer stalled.
        pop_en = 1'b0;
        lat_en = 1'b0;
        cs_assert();
        for (int i = 0; i < 6; i++) spi_byte(8'h10 + 8'(i), 8'hFF, (i < 4));
        cs_release();
        check("overflow_set", bus.rx_overflow, 1);
        check("held_valid", bus.rd_valid, 1);
        pop_en = 1'b1;
        drain();
        check("overflow_sticky", bus.rx_overflow, 1);
        lat_en = 1'b1;
        pop_en = 1'b0;
        s0 = start_cnt;
        cs_assert();
        check("overflow_cleared", bus.rx_overflow, 0);
        spi_byte(8'h20, 8'hFF, 1'b0);
        spi_byte(8'h21, 8'hFF, 1'b0);
        cs_release();
        check("queued_valid", bus.rd_valid, 1);
        cs_assert();
        check("flush_empty", bus.rd_valid, 0);
        cs_release();
        check("start_ovf", start_cnt - s0, 2);
        pop_en = 1'b1;

        // Aborted partial byte, then a clean byte.
        s0 = start_cnt;
        cs_assert();
        spi_bits(8'hFF, 5, junk);
        cs_release();
        cs_assert();
        spi_byte(8'h42, 8'hFF, 1'b1);
        cs_release();
        drain();
        check("start_abort", start_cnt - s0, 2);

        // Reset in the middle of a byte with two bytes queued.
        pop_en = 1'b0;
        cs_assert();
        spi_byte(8'h71, 8'hFF, 1'b0);
        spi_byte(8'h72, 8'hFF, 1'b0);
        spi_bits(8'hF0, 3, junk);
        check("pre_reset_valid", bus.rd_valid, 1);
        s0 = start_cnt;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_overflow", bus.rx_overflow, 0);
        check("reset_underrun", bus.tx_underrun, 0);
        reset = 1'b0;
        spi_bits(8'h00, 5, junk);
        spi_bits(8'h73, 8, junk);
        repeat (6) @(negedge clk);
        check("post_reset_ignored", bus.rd_valid, 0);
        check("post_reset_nostart", start_cnt - s0, 0);
        pop_en = 1'b1;
        cs_release();
        s0 = start_cnt;
        cs_assert();
        spi_byte(8'h99, 8'hFF, 1'b1);
        cs_release();
        drain();
        check("start_fresh", start_cnt - s0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
